// File: rtl/mesh_output_deskew.sv
// Re-aligns skewed mesh bottom-edge rows through per-column delay lines and queues
// complete rows in a circular FIFO with a valid/ready head and an issue throttle.
module mesh_output_deskew #(
    parameter int COLUMNS         = 4,
    parameter int OUTPUT_BITWIDTH = 32,
    parameter int DEPTH           = 8
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic signed [OUTPUT_BITWIDTH-1:0] in_c [COLUMNS],
    input  logic        [COLUMNS-1:0]         in_valid,
    output logic signed [OUTPUT_BITWIDTH-1:0] out_c [COLUMNS],
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic                              almost_full,
    output logic        [$clog2(DEPTH+1)-1:0] count,
    output logic                              overflow_err,
    output logic                              skew_err
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
    localparam logic [CW-1:0] AF_COUNT   = CW'(DEPTH - COLUMNS);
    localparam logic [PW-1:0] LAST_PTR   = PW'(DEPTH - 1);

    logic signed [OUTPUT_BITWIDTH-1:0] w_al_data [COLUMNS];
    logic        [COLUMNS-1:0]         w_al_valid;

    for (genvar j = 0; j < COLUMNS; j++) begin : g_col
        localparam int STAGES = COLUMNS - 1 - j;
        if (STAGES == 0) begin : g_direct
            assign w_al_data[j]  = in_c[j];
            assign w_al_valid[j] = in_valid[j];
        end else begin : g_dly
            logic signed [OUTPUT_BITWIDTH-1:0] r_d [STAGES];
            logic        [STAGES-1:0]          r_v;

            always_ff @(posedge clock) begin
                r_d[0] <= in_c[j];
                for (int k = 1; k < STAGES; k++) begin
                    r_d[k] <= r_d[k-1];
                end
            end

            // Only the valid bits are cleared so in-flight rows vanish on reset.
            always_ff @(posedge clock) begin
                if (reset) begin
                    r_v <= '0;
                end else begin
                    r_v[0] <= in_valid[j];
                    for (int k = 1; k < STAGES; k++) begin
                        r_v[k] <= r_v[k-1];
                    end
                end
            end

            assign w_al_data[j]  = r_d[STAGES-1];
            assign w_al_valid[j] = r_v[STAGES-1];
        end
    end

    logic signed [OUTPUT_BITWIDTH-1:0] r_mem [DEPTH][COLUMNS];
    logic        [PW-1:0]              r_wr_ptr;
    logic        [PW-1:0]              r_rd_ptr;
    logic        [CW-1:0]              r_count;
    logic                              r_ovf;
    logic                              r_skew;

    logic w_all_valid;
    logic w_skew;
    logic w_full;
    logic w_pop;
    logic w_push;
    logic w_ovf;

    assign w_all_valid = &w_al_valid;
    assign w_skew      = (|w_al_valid) && !w_all_valid;
    assign w_full      = (r_count == FULL_COUNT);
    assign w_pop       = out_valid && out_ready;
    // A pop frees the head slot in the same edge, so full+pop still accepts the row.
    assign w_push      = w_all_valid && (!w_full || w_pop);
    assign w_ovf       = w_all_valid && w_full && !w_pop;

    always_ff @(posedge clock) begin
        if (w_push) begin
            for (int j = 0; j < COLUMNS; j++) begin
                r_mem[r_wr_ptr][j] <= w_al_data[j];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
            r_skew   <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - 1'b1;
            end
            if (w_ovf) begin
                r_ovf <= 1'b1;
            end
            if (w_skew) begin
                r_skew <= 1'b1;
            end
        end
    end

    always_comb begin
        for (int j = 0; j < COLUMNS; j++) begin
            out_c[j] = r_mem[r_rd_ptr][j];
        end
    end

    assign out_valid    = (r_count != '0);
    assign count        = r_count;
    assign almost_full  = (r_count >= AF_COUNT);
    assign overflow_err = r_ovf;
    assign skew_err     = r_skew;

endmodule

// File: tb/tb_mesh_output_deskew.sv
// Bench for mesh_output_deskew: vector table, hand-written corner sequences and random
// stall traffic, all checked against a queue-based model of skewed rows.
module tb_mesh_output_deskew;
    localparam int COLUMNS = 4;
    localparam int W       = 32;
    localparam int DEPTH   = 8;
    localparam int HIST    = 16;

    typedef logic [COLUMNS-1:0][W-1:0] row_t;
    typedef struct {
        int   start;
        row_t vals;
        int   late;
    } launch_t;
    typedef struct {
        logic [COLUMNS-1:0] v;
        row_t               c;
        logic               rdy;
        logic               ev;
        logic [3:0]         ecnt;
    } vec_t;

    logic                clock = 1'b0;
    logic                reset;
    logic signed [W-1:0] in_c [COLUMNS];
    logic [COLUMNS-1:0]  in_valid;
    logic signed [W-1:0] out_c [COLUMNS];
    logic                out_valid;
    logic                out_ready;
    logic                almost_full;
    logic [3:0]          count;
    logic                overflow_err;
    logic                skew_err;

    mesh_output_deskew #(
        .COLUMNS        (COLUMNS),
        .OUTPUT_BITWIDTH(W),
        .DEPTH          (DEPTH)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .in_c        (in_c),
        .in_valid    (in_valid),
        .out_c       (out_c),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .almost_full (almost_full),
        .count       (count),
        .overflow_err(overflow_err),
        .skew_err    (skew_err)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    // Model: input history plus a queue of complete rows.
    row_t               mq[$];
    bit                 m_ovf   = 0;
    bit                 m_skew  = 0;
    logic [COLUMNS-1:0] hv [HIST];
    row_t               hc [HIST];
    int                 cyc     = 0;
    int                 rst_cyc = -1000;
    bit                 model_on = 0;
    int                 pops    = 0;
    launch_t            sq[$];
    row_t               drv_c;
    logic [COLUMNS-1:0] drv_v;
    bit                 cur_rst;
    bit                 cur_rdy;

    task automatic chk(string name, logic signed [63:0] act, logic signed [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic row_t mk(int a, int b, int c, int d);
        row_t r;
        r[0] = a;
        r[1] = b;
        r[2] = c;
        r[3] = d;
        return r;
    endfunction

    task automatic launch(int start, row_t vals, int late);
        launch_t l;
        l.start = start;
        l.vals  = vals;
        l.late  = late;
        sq.push_back(l);
    endtask

    task automatic apply(bit rst, bit rdy, bit use_sched);
        int t;
        if (use_sched) begin
            drv_v = '0;
            drv_c = '0;
            foreach (sq[i]) begin
                for (int j = 0; j < COLUMNS; j++) begin
                    t = sq[i].start + j + ((j == sq[i].late) ? 1 : 0);
                    if (t == cyc) begin
                        drv_v[j] = 1'b1;
                        drv_c[j] = sq[i].vals[j];
                    end
                end
            end
        end
        cur_rst   = rst;
        cur_rdy   = rdy;
        reset     = rst;
        out_ready = rdy;
        in_valid  = drv_v;
        for (int j = 0; j < COLUMNS; j++) in_c[j] = drv_c[j];
        #1;
        if (model_on) begin
            chk("out_valid", out_valid, mq.size() != 0);
            chk("count", count, mq.size());
            chk("almost_full", almost_full, (DEPTH - mq.size()) <= COLUMNS);
            chk("overflow_err", overflow_err, m_ovf);
            chk("skew_err", skew_err, m_skew);
            if (mq.size() != 0) begin
                for (int j = 0; j < COLUMNS; j++) chk("out_c", out_c[j], $signed(mq[0][j]));
            end
        end
    endtask

    task automatic advance();
        row_t               al;
        logic [COLUMNS-1:0] av;
        int                 idx;
        hv[cyc % HIST] = drv_v;
        hc[cyc % HIST] = drv_c;
        // Column j of the aligned row is whatever column j received COLUMNS-1-j cycles ago.
        for (int j = 0; j < COLUMNS; j++) begin
            idx   = cyc - (COLUMNS - 1 - j);
            av[j] = 1'b0;
            al[j] = '0;
            if (idx > rst_cyc && idx >= 0) begin
                av[j] = hv[idx % HIST][j];
                al[j] = hc[idx % HIST][j];
            end
        end
        if (cur_rst) begin
            mq.delete();
            m_ovf    = 0;
            m_skew   = 0;
            rst_cyc  = cyc;
            model_on = 1;
        end else begin
            if (mq.size() != 0 && cur_rdy) begin
                void'(mq.pop_front());
                pops++;
            end
            if (&av) begin
                if (mq.size() < DEPTH) mq.push_back(al);
                else m_ovf = 1;
            end else if (|av) begin
                m_skew = 1;
            end
        end
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic tick(bit rst, bit rdy);
        apply(rst, rdy, 1'b1);
        advance();
    endtask

    task automatic fill8(int base);
        for (int k = 0; k < 8; k++) begin
            launch(cyc + k, mk(base + k, base + k + 100, base + k + 200, base + k + 300), -1);
        end
        for (int n = 0; n < 11; n++) tick(0, 0);
    endtask

    task automatic drain(int n, int first);
        row_t e;
        for (int k = 0; k < n; k++) begin
            e = mk(first + k, first + k + 100, first + k + 200, first + k + 300);
            apply(0, 1, 1);
            chk("drain_valid", out_valid, 1);
            for (int j = 0; j < COLUMNS; j++) chk("drain_data", out_c[j], $signed(e[j]));
            advance();
        end
    endtask

    vec_t tbl [6];
    int   launched;
    int   pops0;
    int   guard;

    initial begin
        tbl[0] = '{v: 4'b0001, c: mk(10, 0, 0, 0),   rdy: 1'b1, ev: 1'b0, ecnt: 4'd0};
        tbl[1] = '{v: 4'b0010, c: mk(0, -20, 0, 0),  rdy: 1'b1, ev: 1'b0, ecnt: 4'd0};
        tbl[2] = '{v: 4'b0100, c: mk(0, 0, 30, 0),   rdy: 1'b1, ev: 1'b0, ecnt: 4'd0};
        tbl[3] = '{v: 4'b1000, c: mk(0, 0, 0, -40),  rdy: 1'b1, ev: 1'b0, ecnt: 4'd0};
        tbl[4] = '{v: 4'b0000, c: mk(0, 0, 0, 0),    rdy: 1'b1, ev: 1'b1, ecnt: 4'd1};
        tbl[5] = '{v: 4'b0000, c: mk(0, 0, 0, 0),    rdy: 1'b1, ev: 1'b0, ecnt: 4'd0};

        drv_v = '0;
        drv_c = '0;
        tick(1, 0);
        tick(1, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_count", count, 0);
        chk("rst_almost_full", almost_full, 0);
        chk("rst_overflow_err", overflow_err, 0);
        chk("rst_skew_err", skew_err, 0);
        for (int n = 0; n < 3; n++) tick(0, 1);

        // Alignment and latency: one row, column j valid at cycle 5+j.
        for (int k = 0; k < 6; k++) begin
            drv_v = tbl[k].v;
            drv_c = tbl[k].c;
            apply(0, tbl[k].rdy, 1'b0);
            chk("tbl_valid", out_valid, tbl[k].ev);
            chk("tbl_count", count, tbl[k].ecnt);
            if (tbl[k].ev) begin
                chk("tbl_c0", out_c[0], 10);
                chk("tbl_c1", out_c[1], -20);
                chk("tbl_c2", out_c[2], 30);
                chk("tbl_c3", out_c[3], -40);
            end
            advance();
        end

        // Back-to-back rows, then overflow with a held consumer.
        fill8(0);
        chk("b2b_count", count, 8);
        chk("b2b_almost_full", almost_full, 1);
        launch(cyc, mk(900, 901, 902, 903), -1);
        for (int n = 0; n < 5; n++) tick(0, 0);
        chk("ovf_flag", overflow_err, 1);
        chk("ovf_count", count, 8);
        chk("ovf_head", out_c[0], 0);
        drain(8, 0);
        tick(0, 1);
        chk("drain_empty", count, 0);

        // Full with a pop in the push cycle is not overflow.
        sq.delete();
        tick(1, 0);
        fill8(0);
        launch(cyc, mk(900, 1000, 1100, 1200), -1);
        for (int n = 0; n < 3; n++) tick(0, 0);
        tick(0, 1);
        tick(0, 0);
        chk("fullpop_ovf", overflow_err, 0);
        chk("fullpop_count", count, 8);
        drain(7, 1);
        drain(1, 900);

        // Skew error: column 2 one cycle late.
        sq.delete();
        tick(1, 0);
        launch(cyc, mk(1, 2, 3, 4), 2);
        for (int n = 0; n < 6; n++) tick(0, 0);
        chk("skew_flag", skew_err, 1);
        chk("skew_no_push", count, 0);
        for (int n = 0; n < 3; n++) tick(0, 0);
        chk("skew_held", skew_err, 1);
        launch(cyc, mk(5, 6, 7, 8), -1);
        for (int n = 0; n < 5; n++) tick(0, 0);
        chk("skew_next_count", count, 1);
        chk("skew_next_data", out_c[0], 5);

        // Reset with 3 rows queued and 2 in flight.
        launch(cyc, mk(11, 12, 13, 14), -1);
        launch(cyc + 1, mk(21, 22, 23, 24), -1);
        for (int n = 0; n < 5; n++) tick(0, 0);
        chk("pre_rst_count", count, 3);
        launch(cyc, mk(31, 32, 33, 34), -1);
        launch(cyc + 1, mk(41, 42, 43, 44), -1);
        tick(0, 0);
        tick(0, 0);
        sq.delete();
        tick(1, 0);
        chk("midrst_valid", out_valid, 0);
        chk("midrst_count", count, 0);
        chk("midrst_ovf", overflow_err, 0);
        chk("midrst_skew", skew_err, 0);
        for (int n = 0; n < 10; n++) tick(0, 1);
        chk("midrst_no_stale", count, 0);

        // Random stalls honouring almost_full; 20 rows wrap the pointers.
        launched = 0;
        pops0    = pops;
        guard    = 0;
        while ((pops - pops0) < 20 && guard < 3000) begin
            if (launched < 20 && !almost_full && $urandom_range(0, 3) != 0) begin
                launch(cyc, mk(5000 + launched, -launched, $urandom, -5000 - launched), -1);
                launched++;
            end
            tick(0, 1'($urandom_range(0, 1)));
            guard++;
        end
        chk("stall_rows", pops - pops0, 20);
        chk("stall_ovf", overflow_err, 0);
        chk("stall_empty", count, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mesh_output_deskew.md
Name: mesh_output_deskew

Overview:
- Receives result rows leaving the bottom edge of the systolic mesh.
- Each row arrives skewed: column j's element arrives j cycles after column 0's.
- The block re-aligns each row with per-column delay lines and buffers aligned rows in a FIFO.
- It presents each row as one vector on a valid/ready interface to the writeback logic, and gives the array controller an issue-throttle signal.

Parameters:
- COLUMNS, 4, total output columns (MESHCOLUMNS*TILECOLUMNS); must be >= 1.
- OUTPUT_BITWIDTH, 32, width of each signed result element.
- DEPTH, 8, row FIFO depth in entries; must be >= COLUMNS+1.

Ports:
- clock  input  1  single clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- in_c[COLUMNS-1:0]  input  OUTPUT_BITWIDTH signed each  mesh bottom-edge results; column j lags column 0 by j cycles.
- in_valid[COLUMNS-1:0]  input  1 each  per-column valid, with the same skew as in_c.
- out_c[COLUMNS-1:0]  output  OUTPUT_BITWIDTH signed each  aligned row at the FIFO head.
- out_valid  output  1  head row is present.
- out_ready  input  1  consumer accepts the head row.
- almost_full  output  1  controller must not launch a new row while this is high.
- count  output  $clog2(DEPTH+1)  number of rows held in the FIFO.
- overflow_err  output  1  sticky: an aligned row arrived while the FIFO was full.
- skew_err  output  1  sticky: aligned valid bits disagreed.

Behaviour:
- Alignment
  - Column j passes through a registered delay line of COLUMNS-1-j stages; column COLUMNS-1 has zero delay.
  - Both data and valid are delayed.
  - Aligned row = all delay-line outputs in the same cycle.
  - Data of a row whose column-0 element arrives at cycle t becomes aligned combinationally at cycle t+COLUMNS-1.
  - It is written into the FIFO on that cycle's clock edge.
  - It is visible on out_c/out_valid from cycle t+COLUMNS. Fixed latency is COLUMNS cycles when the FIFO is empty.
- Push
  - Condition: all aligned valid bits are 1 and the FIFO is not full.
- Skew error
  - Raised when aligned valid bits are neither all-0 nor all-1.
  - That row is dropped and skew_err sets to 1, holding until reset.
- Overflow error
  - Raised when all aligned valid bits are 1 and the FIFO is full, with no pop in the same cycle.
  - The row is dropped and overflow_err sets.
  - Full with a simultaneous pop is not overflow: the pop and push both occur and count is unchanged.
- Pop
  - A pop occurs when out_valid && out_ready.
  - The head advances on the clock edge.
  - out_c is stable while out_valid=1 and out_ready=0.
- FIFO
  - Circular buffer of DEPTH entries; read/write pointers wrap from DEPTH-1 to 0.
  - count = pushes - pops, range 0..DEPTH.
  - Simultaneous push and pop at count=0 is not allowed to bypass: the pushed row appears the next cycle.
  - out_valid = (count != 0).
  - out_c is the head entry; its value is don't-care when out_valid=0.
- Throttle
  - almost_full = (DEPTH - count) <= COLUMNS, i.e. free entries are not enough to cover rows already in flight in the delay lines plus one.
  - A controller that obeys almost_full can never cause overflow.
- Data
  - Values pass through unmodified; no arithmetic and no sign or width change.
- Reset, including mid-operation
  - All delay-line valid bits clear, so in-flight rows are discarded.
  - FIFO pointers and count go to 0.
  - Output reset values: out_valid=0, count=0, almost_full=0 (DEPTH > COLUMNS), overflow_err=0, skew_err=0.
  - out_c data registers need not reset.
  - Inputs sampled in the reset cycle are ignored.
- COLUMNS=1: no delay stages; latency is 1 cycle.

Test Plan:
- Alignment and latency (COLUMNS=4, DEPTH=8, out_ready=1)
  - Stimulus: drive one skewed row {10,-20,30,-40} with column j valid at cycle 5+j.
  - Required: out_valid=1 only in cycle 9, out_c={10,-20,30,-40}, count returns to 0.
- Back-to-back rows
  - Stimulus: 8 consecutive skewed rows (row k = {k,k+100,k+200,k+300}) with out_ready=0.
  - Required: count reaches 8 and almost_full=1 once count >= 4.
  - Then raising out_ready drains the rows in order k=0..7, one per cycle.
- Overflow
  - Stimulus: with the FIFO full (count=8) and out_ready=0, push a 9th row.
  - Required: overflow_err=1, count stays 8, contents unchanged.
  - Repeat with out_ready=1 in the push cycle: overflow_err stays 0 and count stays 8.
- Skew error
  - Stimulus: drive column 2 valid one cycle late.
  - Required: no push, skew_err=1 and held.
  - A following correctly skewed row is still pushed normally.
- Reset mid-operation
  - Stimulus: assert reset with 2 rows in flight in the delay lines and 3 in the FIFO.
  - Required: in the next cycle out_valid=0, count=0, both error flags 0.
  - No stale row ever appears afterwards.
- Stall stability and wrap
  - Stimulus: run 20 rows through DEPTH=8 with random out_ready while honouring almost_full.
  - Required: pointers wrap, out_c never changes while the head is held, and output order matches input order with no loss.
